// File: rtl/idex_stage_pkg.sv
// Shared ALU encodings, the ID/EX pipeline register layout and the forwarding-match helper.
// The existing ALU uses the same alucont encodings.
package idex_stage_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;

    // bit2 inverts b and sets carry-in; bits1:0 pick and/or/sum/slt
    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        logic        branch;
        logic        nez;
        logic        illegal;
        logic        alusrc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  writereg;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] signimm;
        logic [2:0]  alucont;
    } ex_regs_t;

    function automatic ex_regs_t ex_bubble();
        ex_regs_t b;
        b         = '0;
        b.alucont = ALUC_ADD;
        return b;
    endfunction

    function automatic logic fwd_hit(input logic regwrite, input logic [4:0] writereg,
                                     input logic [4:0] spec);
        return regwrite && (writereg == spec) && (spec != 5'd0);
    endfunction

endpackage

// File: rtl/idex_stage_if.sv
// ID/EX stage bus: decode-side inputs, MEM/WB forwarding sources and EX-side outputs.
interface idex_stage_if;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_rd1;
    logic [31:0] id_rd2;
    logic [31:0] id_signimm;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        id_alusrc;
    logic        id_regdst;
    logic        id_regwrite;
    logic        id_memtoreg;
    logic        id_memwrite;
    logic        id_branch;
    logic        id_bne;
    logic        mem_regwrite;
    logic [4:0]  mem_writereg;
    logic [31:0] mem_aluout;
    logic        wb_regwrite;
    logic [4:0]  wb_writereg;
    logic [31:0] wb_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alucont;
    logic        nez;
    logic        ex_valid;
    logic        ex_regwrite;
    logic        ex_memtoreg;
    logic        ex_memwrite;
    logic        ex_branch;
    logic [4:0]  ex_writereg;
    logic [31:0] ex_writedata;
    logic        ex_illegal;

    modport master (
        output stall, flush, id_valid, id_rd1, id_rd2, id_signimm, id_rs, id_rt, id_rd,
               id_aluop, id_funct, id_alusrc, id_regdst, id_regwrite, id_memtoreg,
               id_memwrite, id_branch, id_bne, mem_regwrite, mem_writereg, mem_aluout,
               wb_regwrite, wb_writereg, wb_result,
        input  alu_a, alu_b, alucont, nez, ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite,
               ex_branch, ex_writereg, ex_writedata, ex_illegal
    );

    modport slave (
        input  stall, flush, id_valid, id_rd1, id_rd2, id_signimm, id_rs, id_rt, id_rd,
               id_aluop, id_funct, id_alusrc, id_regdst, id_regwrite, id_memtoreg,
               id_memwrite, id_branch, id_bne, mem_regwrite, mem_writereg, mem_aluout,
               wb_regwrite, wb_writereg, wb_result,
        output alu_a, alu_b, alucont, nez, ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite,
               ex_branch, ex_writereg, ex_writedata, ex_illegal
    );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational ALU control decode: aluop/funct -> alucont plus an unsupported-funct flag.
module alu_ctrl_dec
    import idex_stage_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucont,
    output logic       illegal
);

    always_comb begin
        alucont = ALUC_ADD;
        illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: alucont = ALUC_ADD;
            ALUOP_SUB: alucont = ALUC_SUB;
            ALUOP_OR:  alucont = ALUC_OR;
            default: begin
                case (funct)
                    FUNCT_ADD, FUNCT_ADDU: alucont = ALUC_ADD;
                    FUNCT_SUB, FUNCT_SUBU: alucont = ALUC_SUB;
                    FUNCT_AND:             alucont = ALUC_AND;
                    FUNCT_OR:              alucont = ALUC_OR;
                    FUNCT_SLT:             alucont = ALUC_SLT;
                    default: begin
                        alucont = ALUC_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with registered ALU decode and combinational MEM/WB operand forwarding.
// One-cycle latency; stall holds the register, flush (higher priority) or id_valid=0 loads a bubble.
module idex_stage
    import idex_stage_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    idex_stage_if.slave  bus
);

    logic [2:0] dec_alucont;
    logic       dec_illegal;
    ex_regs_t   ex_d;
    ex_regs_t   ex_q;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    alu_ctrl_dec u_alu_ctrl_dec (
        .aluop   (bus.id_aluop),
        .funct   (bus.id_funct),
        .alucont (dec_alucont),
        .illegal (dec_illegal)
    );

    always_comb begin
        ex_d          = ex_bubble();
        ex_d.valid    = 1'b1;
        // an unsupported funct must never write the register file
        ex_d.regwrite = bus.id_regwrite & ~dec_illegal;
        ex_d.memtoreg = bus.id_memtoreg;
        ex_d.memwrite = bus.id_memwrite;
        ex_d.branch   = bus.id_branch;
        ex_d.nez      = bus.id_branch & bus.id_bne;
        ex_d.illegal  = dec_illegal;
        ex_d.alusrc   = bus.id_alusrc;
        ex_d.rs       = bus.id_rs;
        ex_d.rt       = bus.id_rt;
        ex_d.writereg = bus.id_regdst ? bus.id_rd : bus.id_rt;
        ex_d.rd1      = bus.id_rd1;
        ex_d.rd2      = bus.id_rd2;
        ex_d.signimm  = bus.id_signimm;
        ex_d.alucont  = dec_alucont;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= ex_bubble();
        end else if (bus.flush) begin
            ex_q <= ex_bubble();
        end else if (bus.stall) begin
            ex_q <= ex_q;
        end else if (!bus.id_valid) begin
            ex_q <= ex_bubble();
        end else begin
            ex_q <= ex_d;
        end
    end

    // MEM is the younger producer, so it wins over WB on a double match
    always_comb begin
        fwd_rs = ex_q.rd1;
        if (fwd_hit(bus.mem_regwrite, bus.mem_writereg, ex_q.rs)) begin
            fwd_rs = bus.mem_aluout;
        end else if (fwd_hit(bus.wb_regwrite, bus.wb_writereg, ex_q.rs)) begin
            fwd_rs = bus.wb_result;
        end

        fwd_rt = ex_q.rd2;
        if (fwd_hit(bus.mem_regwrite, bus.mem_writereg, ex_q.rt)) begin
            fwd_rt = bus.mem_aluout;
        end else if (fwd_hit(bus.wb_regwrite, bus.wb_writereg, ex_q.rt)) begin
            fwd_rt = bus.wb_result;
        end
    end

    assign bus.alu_a        = fwd_rs;
    assign bus.alu_b        = ex_q.alusrc ? ex_q.signimm : fwd_rt;
    assign bus.ex_writedata = fwd_rt;
    assign bus.alucont      = ex_q.alucont;
    assign bus.nez          = ex_q.nez;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_regwrite  = ex_q.regwrite;
    assign bus.ex_memtoreg  = ex_q.memtoreg;
    assign bus.ex_memwrite  = ex_q.memwrite;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_writereg  = ex_q.writereg;
    assign bus.ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_idex_stage.sv
// Bench for idex_stage: directed vector table, hand-written stall/flush/reset sequences, random run vs model.
module tb_idex_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    idex_stage_if bus ();
    idex_stage dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit        valid, regwrite, memtoreg, memwrite, branch, nez, illegal, alusrc;
        bit [4:0]  rs, rt, wreg;
        bit [31:0] rd1, rd2, imm;
        bit [2:0]  alucont;
    } m_t;

    m_t m;

    typedef struct {
        bit [1:0]  aluop;
        bit [5:0]  funct;
        bit        br, bne, rw, regdst, alusrc;
        bit [4:0]  rs, rt, rd;
        bit [31:0] rd1, rd2, imm;
        bit        mrw;
        bit [4:0]  mwr;
        bit [31:0] mout;
        bit        wrw;
        bit [4:0]  wwr;
        bit [31:0] wres;
        bit [2:0]  e_alucont;
        bit        e_ill, e_rw, e_nez;
        bit [31:0] e_a, e_b;
        bit [4:0]  e_wreg;
        bit [31:0] e_wdata;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic m_t bubble();
        m_t b;
        b = '{default: 0};
        b.alucont = 3'd2;
        return b;
    endfunction

    // {illegal, alucont} from the written opcode/funct table
    function automatic bit [3:0] ref_dec(input bit [1:0] aluop, input bit [5:0] funct);
        if (aluop == 2'd0) return 4'd2;
        if (aluop == 2'd1) return 4'd6;
        if (aluop == 2'd3) return 4'd1;
        case (funct)
            6'd32, 6'd33: return 4'd2;
            6'd34, 6'd35: return 4'd6;
            6'd36:        return 4'd0;
            6'd37:        return 4'd1;
            6'd42:        return 4'd7;
            default:      return 4'b1010;
        endcase
    endfunction

    function automatic bit [31:0] ref_fwd(input bit [4:0] spec, input bit [31:0] regval);
        if (spec != 0 && bus.mem_regwrite && bus.mem_writereg == spec) return bus.mem_aluout;
        if (spec != 0 && bus.wb_regwrite && bus.wb_writereg == spec) return bus.wb_result;
        return regval;
    endfunction

    function automatic m_t capture();
        m_t c;
        bit [3:0] d;
        d          = ref_dec(bus.id_aluop, bus.id_funct);
        c.valid    = 1'b1;
        c.illegal  = d[3];
        c.alucont  = d[2:0];
        c.regwrite = bus.id_regwrite && !d[3];
        c.memtoreg = bus.id_memtoreg;
        c.memwrite = bus.id_memwrite;
        c.branch   = bus.id_branch;
        c.nez      = bus.id_branch && bus.id_bne;
        c.alusrc   = bus.id_alusrc;
        c.rs       = bus.id_rs;
        c.rt       = bus.id_rt;
        c.wreg     = bus.id_regdst ? bus.id_rd : bus.id_rt;
        c.rd1      = bus.id_rd1;
        c.rd2      = bus.id_rd2;
        c.imm      = bus.id_signimm;
        return c;
    endfunction

    task automatic step();
        m_t nx;
        if (bus.flush)          nx = bubble();
        else if (bus.stall)     nx = m;
        else if (!bus.id_valid) nx = bubble();
        else                    nx = capture();
        @(posedge clk);
        #1;
        m = nx;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ex_valid"},     32'(bus.ex_valid),    32'(m.valid));
        chk({tag, ".ex_regwrite"},  32'(bus.ex_regwrite), 32'(m.regwrite));
        chk({tag, ".ex_memtoreg"},  32'(bus.ex_memtoreg), 32'(m.memtoreg));
        chk({tag, ".ex_memwrite"},  32'(bus.ex_memwrite), 32'(m.memwrite));
        chk({tag, ".ex_branch"},    32'(bus.ex_branch),   32'(m.branch));
        chk({tag, ".nez"},          32'(bus.nez),         32'(m.nez));
        chk({tag, ".ex_illegal"},   32'(bus.ex_illegal),  32'(m.illegal));
        chk({tag, ".alucont"},      32'(bus.alucont),     32'(m.alucont));
        chk({tag, ".ex_writereg"},  32'(bus.ex_writereg), 32'(m.wreg));
        chk({tag, ".alu_a"},        bus.alu_a,            ref_fwd(m.rs, m.rd1));
        chk({tag, ".alu_b"},        bus.alu_b,            m.alusrc ? m.imm : ref_fwd(m.rt, m.rd2));
        chk({tag, ".ex_writedata"}, bus.ex_writedata,     ref_fwd(m.rt, m.rd2));
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
        bus.id_rd1 = 0; bus.id_rd2 = 0; bus.id_signimm = 0;
        bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
        bus.id_aluop = 0; bus.id_funct = 0;
        bus.id_alusrc = 0; bus.id_regdst = 0; bus.id_regwrite = 0; bus.id_memtoreg = 0;
        bus.id_memwrite = 0; bus.id_branch = 0; bus.id_bne = 0;
        bus.mem_regwrite = 0; bus.mem_writereg = 0; bus.mem_aluout = 0;
        bus.wb_regwrite = 0; bus.wb_writereg = 0; bus.wb_result = 0;
    endtask

    task automatic randomize_id();
        bit [5:0] legal[7] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd42};
        bus.id_rd1 = $urandom; bus.id_rd2 = $urandom; bus.id_signimm = $urandom;
        bus.id_rs = 5'($urandom_range(0, 7)); bus.id_rt = 5'($urandom_range(0, 7));
        bus.id_rd = 5'($urandom_range(0, 31));
        bus.id_aluop = 2'($urandom_range(0, 3));
        bus.id_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 6)];
        bus.id_alusrc = 1'($urandom); bus.id_regdst = 1'($urandom);
        bus.id_regwrite = 1'($urandom); bus.id_memtoreg = 1'($urandom);
        bus.id_memwrite = 1'($urandom); bus.id_branch = 1'($urandom); bus.id_bne = 1'($urandom);
    endtask

    task automatic randomize_fwd();
        bus.mem_regwrite = 1'($urandom); bus.mem_writereg = 5'($urandom_range(0, 7));
        bus.mem_aluout = $urandom;
        bus.wb_regwrite = 1'($urandom); bus.wb_writereg = 5'($urandom_range(0, 7));
        bus.wb_result = $urandom;
    endtask

    initial begin
        clear_inputs();
        m = bubble();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        chk("reset.alucont_const", 32'(bus.alucont), 32'd2);
        reset = 1'b0;

        //         aluop funct      br bne rw dst src rs rt rd rd1         rd2         imm           mrw mwr mout      wrw wwr wres  e_alc ill rw nez e_a        e_b          e_wr e_wdata
        vecs[0] = '{2'd2, 6'b100010, 0, 0, 1, 1, 0, 1, 2, 9, 32'd7,      32'd3,      32'd0,        0, 0, 32'h0,     0, 0, 32'h0,  3'd6, 0, 1, 0, 32'd7,     32'd3,       9,  32'd3};
        vecs[1] = '{2'd0, 6'd0,      0, 0, 1, 0, 0, 5, 6, 3, 32'hAAAA,   32'hBBBB,   32'd0,        1, 5, 32'h11,    1, 6, 32'h22, 3'd2, 0, 1, 0, 32'h11,    32'h22,      6,  32'h22};
        vecs[2] = '{2'd0, 6'd0,      0, 0, 1, 0, 0, 5, 7, 3, 32'hAAAA,   32'h44,     32'd0,        1, 5, 32'h11,    1, 5, 32'h22, 3'd2, 0, 1, 0, 32'h11,    32'h44,      7,  32'h44};
        vecs[3] = '{2'd3, 6'd0,      0, 0, 1, 0, 0, 0, 0, 3, 32'd0,      32'd5,      32'd0,        1, 0, 32'hFFFF,  1, 0, 32'h33, 3'd1, 0, 1, 0, 32'd0,     32'd5,       0,  32'd5};
        vecs[4] = '{2'd2, 6'b000000, 0, 0, 1, 1, 0, 1, 2, 4, 32'd1,      32'd2,      32'd0,        0, 0, 32'h0,     0, 0, 32'h0,  3'd2, 1, 0, 0, 32'd1,     32'd2,       4,  32'd2};
        vecs[5] = '{2'd1, 6'd0,      1, 1, 0, 0, 0, 3, 4, 0, 32'd10,     32'd20,     32'd0,        0, 0, 32'h0,     0, 0, 32'h0,  3'd6, 0, 0, 1, 32'd10,    32'd20,      4,  32'd20};
        vecs[6] = '{2'd2, 6'b101010, 0, 0, 1, 0, 1, 2, 4, 1, 32'd8,      32'd9,      32'hFFFFFFF0, 0, 0, 32'h0,     1, 4, 32'h99, 3'd7, 0, 1, 0, 32'd8,     32'hFFFFFFF0,4,  32'h99};
        vecs[7] = '{2'd2, 6'b100101, 1, 0, 1, 1, 0, 6, 7, 31,32'd3,      32'd4,      32'd0,        0, 6, 32'h55,    1, 0, 32'h66, 3'd1, 0, 1, 0, 32'd3,     32'd4,       31, 32'd4};

        for (int i = 0; i < 8; i++) begin
            bus.id_valid = 1; bus.stall = 0; bus.flush = 0;
            bus.id_aluop = vecs[i].aluop; bus.id_funct = vecs[i].funct;
            bus.id_branch = vecs[i].br; bus.id_bne = vecs[i].bne; bus.id_regwrite = vecs[i].rw;
            bus.id_regdst = vecs[i].regdst; bus.id_alusrc = vecs[i].alusrc;
            bus.id_memtoreg = 0; bus.id_memwrite = 0;
            bus.id_rs = vecs[i].rs; bus.id_rt = vecs[i].rt; bus.id_rd = vecs[i].rd;
            bus.id_rd1 = vecs[i].rd1; bus.id_rd2 = vecs[i].rd2; bus.id_signimm = vecs[i].imm;
            bus.mem_regwrite = vecs[i].mrw; bus.mem_writereg = vecs[i].mwr; bus.mem_aluout = vecs[i].mout;
            bus.wb_regwrite = vecs[i].wrw; bus.wb_writereg = vecs[i].wwr; bus.wb_result = vecs[i].wres;
            step();
            chk($sformatf("vec%0d.ex_valid", i),     32'(bus.ex_valid),    32'd1);
            chk($sformatf("vec%0d.alucont", i),      32'(bus.alucont),     32'(vecs[i].e_alucont));
            chk($sformatf("vec%0d.ex_illegal", i),   32'(bus.ex_illegal),  32'(vecs[i].e_ill));
            chk($sformatf("vec%0d.ex_regwrite", i),  32'(bus.ex_regwrite), 32'(vecs[i].e_rw));
            chk($sformatf("vec%0d.nez", i),          32'(bus.nez),         32'(vecs[i].e_nez));
            chk($sformatf("vec%0d.alu_a", i),        bus.alu_a,            vecs[i].e_a);
            chk($sformatf("vec%0d.alu_b", i),        bus.alu_b,            vecs[i].e_b);
            chk($sformatf("vec%0d.ex_writereg", i),  32'(bus.ex_writereg), 32'(vecs[i].e_wreg));
            chk($sformatf("vec%0d.ex_writedata", i), bus.ex_writedata,     vecs[i].e_wdata);
        end

        // Stall holds A while ID changes; forwarding keeps tracking MEM/WB.
        clear_inputs();
        bus.id_valid = 1; bus.id_aluop = 2'd1; bus.id_rs = 5'd3; bus.id_rt = 5'd4; bus.id_rd = 5'd8;
        bus.id_regdst = 1; bus.id_regwrite = 1; bus.id_rd1 = 32'h100; bus.id_rd2 = 32'h200;
        step();
        check_outputs("stallA");
        bus.stall = 1;
        for (int k = 0; k < 2; k++) begin
            randomize_id();
            step();
            check_outputs($sformatf("stall%0d", k));
            chk($sformatf("stall%0d.alu_a_const", k), bus.alu_a, 32'h100);
        end
        bus.mem_regwrite = 1; bus.mem_writereg = 5'd3; bus.mem_aluout = 32'hBEEF;
        #1;
        chk("stall.fwd_track", bus.alu_a, 32'hBEEF);
        bus.flush = 1;
        step();
        chk("stallflush.ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("stallflush.alucont", 32'(bus.alucont), 32'd2);
        check_outputs("stallflush");

        // id_valid low loads a bubble
        clear_inputs();
        bus.id_valid = 1; bus.id_regwrite = 1; bus.id_memwrite = 1; bus.id_rd1 = 32'h7;
        step();
        bus.id_valid = 0;
        step();
        check_outputs("novalid");

        // Async reset mid-stall clears before the next edge
        bus.id_valid = 1; bus.id_regwrite = 1; bus.id_memwrite = 1; bus.id_memtoreg = 1;
        bus.id_branch = 1; bus.id_bne = 1; bus.id_aluop = 2'd1;
        step();
        chk("prerst.ex_valid", 32'(bus.ex_valid), 32'd1);
        bus.stall = 1;
        #3;
        reset = 1'b1;
        #1;
        m = bubble();
        chk("asyncrst.ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("asyncrst.ex_regwrite", 32'(bus.ex_regwrite), 32'd0);
        chk("asyncrst.ex_memwrite", 32'(bus.ex_memwrite), 32'd0);
        chk("asyncrst.nez", 32'(bus.nez), 32'd0);
        check_outputs("asyncrst");
        #2;
        reset = 1'b0;
        bus.stall = 0;
        step();
        check_outputs("postrst");

        // Random run against the model
        for (int n = 0; n < 400; n++) begin
            randomize_id();
            randomize_fwd();
            bus.id_valid = ($urandom_range(0, 9) < 8);
            bus.stall    = ($urandom_range(0, 9) < 2);
            bus.flush    = ($urandom_range(0, 9) < 1);
            step();
            check_outputs("rnd");
            randomize_fwd();
            #1;
            check_outputs("rndfwd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/idex_stage.md
IDEX_STAGE -- requirements
Module: idex_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  asynchronous, active-high; clears all state.
REQ-003 stall  in  1  hold current ID/EX contents.
REQ-004 flush  in  1  load a bubble on the next edge.
REQ-005 id_valid  in  1  decode-stage instruction present.
REQ-006 id_rd1, id_rd2  in  32 each  register-file read data (rs, rt).
REQ-007 id_signimm  in  32  sign-extended immediate.
REQ-008 id_rs, id_rt, id_rd  in  5 each  register specifiers.
REQ-009 id_aluop  in  2  00 add, 01 sub, 10 use funct, 11 or.
REQ-010 id_funct  in  6  R-type function field.
REQ-011 id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite, id_branch, id_bne  in  1 each  decode controls.
REQ-012 mem_regwrite  in  1; mem_writereg  in  5; mem_aluout  in  32  MEM-stage forwarding source.
REQ-013 wb_regwrite  in  1; wb_writereg  in  5; wb_result  in  32  WB-stage forwarding source.
REQ-014 alu_a, alu_b  out  32 each  ALU operands.
REQ-015 alucont  out  3  ALU control: bit2 invert b and carry-in; bits1:0 00 and, 01 or, 10 sum, 11 slt.
REQ-016 nez  out  1  ALU zero-flag polarity select (1 for bne).
REQ-017 ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_branch  out  1 each  registered controls.
REQ-018 ex_writereg  out  5; ex_writedata  out  32 (forwarded rt); ex_illegal  out  1 (unsupported funct).

Function
REQ-019 On each rising edge with reset low: flush=1 -> bubble; else stall=1 -> hold; else id_valid=0 -> bubble; else capture ID inputs.
REQ-020 flush SHALL take priority over stall when both are asserted in the same cycle.
REQ-021 Bubble: ex_valid, ex_regwrite, ex_memtoreg, ex_memwrite, ex_branch, nez and ex_illegal are 0; all data/specifier fields 0; alucont 3'b010.
REQ-022 Latency: one cycle; inputs sampled at edge N appear on the outputs after edge N.
REQ-023 alucont and ex_illegal decoded at capture time and registered: aluop 00 -> 010; 01 -> 110; 11 -> 001; 10 -> funct.
REQ-024 Funct map: 100000/100001 -> 010; 100010/100011 -> 110; 100100 -> 000; 100101 -> 001; 101010 -> 111; any other -> 010 with ex_illegal=1 and ex_regwrite forced 0.
REQ-025 nez = id_branch & id_bne, registered.
REQ-026 ex_writereg = id_regdst ? id_rd : id_rt, registered.
REQ-027 Forwarding is combinational on the registered rs/rt: MEM source when mem_regwrite=1, mem_writereg equals the specifier and is nonzero; else WB source under the same rule; else the registered read data.
REQ-028 MEM source SHALL win when MEM and WB both match.
REQ-029 Specifier 0 SHALL never be forwarded; a zero specifier passes the registered value.
REQ-030 alu_a = forwarded rs; alu_b = ex alusrc ? registered signimm : forwarded rt; ex_writedata = forwarded rt regardless of alusrc.
REQ-031 While holding under stall, forwarding continues to track the current mem_/wb_ inputs.

Reset
REQ-032 Asserting reset SHALL immediately drive the bubble state of REQ-021 without waiting for a clock edge, including mid-stall.
REQ-033 First capture occurs on the first rising edge after reset deasserts.

Structure
REQ-034 Shared header mips_defs.vh holds the aluop codes, funct codes and alucont encodings; the existing ALU also uses these encodings.
REQ-035 Single sub-module alu_ctrl_dec (aluop, funct -> alucont, illegal), purely combinational; the forwarding muxes live in idex_stage.
REQ-036 Implementation is about 150-250 lines; no latches; registers only in idex_stage.

Verification
REQ-037 Reset, then id_valid=1, aluop=10, funct=100010, rd1=7, rd2=3, rd=9, regdst=1 -> next cycle alucont=110, alu_a=7, alu_b=3, ex_writereg=9, ex_valid=1.
REQ-038 Captured rs=5, rt=6; mem_regwrite=1, mem_writereg=5, mem_aluout=0x11; wb_regwrite=1, wb_writereg=5 and 6, wb_result=0x22 -> alu_a=0x11, alu_b=0x22.
REQ-039 rs=0, mem_writereg=0, mem_regwrite=1, mem_aluout=0xFFFF, rd1=0 -> alu_a=0.
REQ-040 Instruction A captured, then stall=1 for 2 cycles while the ID inputs change -> outputs still show A; stall and flush together -> ex_valid=0, alucont=010.
REQ-041 aluop=10, funct=000000, regwrite=1 -> ex_illegal=1, ex_regwrite=0, alucont=010; branch=1, bne=1 -> nez=1, alucont=110.
REQ-042 Assert reset asynchronously between edges while ex_valid=1 -> ex_valid and all controls 0 before the next edge.
